// File: rtl/ram_responder.sv
// ram_responder: wait-state RAM model serving one cache, broadcasting atomic writes to peer caches
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 32
`endif
module ram_responder #(
    parameter int MEM_AW      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`DATA_ADDR_W-1:0] ram_addr,
    input  logic [`DATA_W-1:0]      ram_data_w,
    input  logic                    ram_read,
    input  logic                    ram_write,
    input  logic                    atomic_i,
    output logic                    ram_wait,
    output logic [`DATA_W-1:0]      ram_data_r,
    output logic                    bcast_valid,
    output logic [`DATA_ADDR_W-1:0] bcast_addr,
    output logic [`DATA_W-1:0]      bcast_data
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [`DATA_ADDR_W-1:0] addr_q, baddr_q;
    logic [`DATA_W-1:0]      data_q, rdata_q, bdata_q;
    logic                    wr_q, at_q, wait_q, bvalid_q;
    logic [`DATA_W-1:0]      mem [2**MEM_AW] = '{default: '0};
    logic                    idle_req, go_ack, cur_wr, cur_at;
    logic [`DATA_ADDR_W-1:0] cur_addr;
    logic [`DATA_W-1:0]      cur_data;
    // With zero wait states the acceptance edge is also the commit edge, so IDLE uses live inputs.
    always_comb begin
        idle_req = state_q == IDLE && (ram_read || ram_write);
        go_ack   = (idle_req && WAIT_CYCLES == 0) || (state_q == BUSY && cnt_q == 4'(WAIT_CYCLES - 1));
        cur_addr = state_q == IDLE ? ram_addr : addr_q;
        cur_data = state_q == IDLE ? ram_data_w : data_q;
        cur_wr   = state_q == IDLE ? ram_write : wr_q;
        cur_at   = state_q == IDLE ? atomic_i : at_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            at_q     <= 1'b0;
            wait_q   <= 1'b1;
            rdata_q  <= '0;
            bvalid_q <= 1'b0;
            baddr_q  <= '0;
            bdata_q  <= '0;
        end else begin
            wait_q   <= !go_ack;
            bvalid_q <= go_ack && cur_wr && cur_at;
            if (go_ack && cur_wr && cur_at) begin
                baddr_q <= cur_addr;
                bdata_q <= cur_data;
            end
            if (go_ack && !cur_wr)
                rdata_q <= mem[cur_addr[MEM_AW-1:0]];
            case (state_q)
                IDLE: if (idle_req) begin
                    addr_q  <= ram_addr;
                    data_q  <= ram_data_w;
                    wr_q    <= ram_write;
                    at_q    <= atomic_i;
                    cnt_q   <= '0;
                    state_q <= WAIT_CYCLES == 0 ? ACK : BUSY;
                end
                BUSY: if (go_ack) state_q <= ACK;
                      else cnt_q <= cnt_q + 4'd1;
                default: state_q <= IDLE;
            endcase
        end
    end
    // Storage survives reset; rst only blocks a commit in flight.
    always_ff @(posedge clk)
        if (go_ack && cur_wr && !rst)
            mem[cur_addr[MEM_AW-1:0]] <= cur_data;
    assign ram_wait    = wait_q;
    assign ram_data_r  = rdata_q;
    assign bcast_valid = bvalid_q;
    assign bcast_addr  = baddr_q;
    assign bcast_data  = bdata_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed vectors against a cycle-count transaction model, two instances (2 and 0 wait states)
module tb_ram_responder;
    localparam int WC [2] = '{2, 0};
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] a [2], d [2], dr [2], ba [2], bd [2];
    logic        rd [2], wr [2], at [2], wt [2], bv [2];
    int          checks = 0, failures = 0, cyc = 0;
    logic [31:0] mm [2][1024];
    int          ack_at [2], free_at [2];
    logic        p_wr [2], p_at [2];
    logic [31:0] p_a [2], p_d [2];
    logic        e_wait [2], e_bv [2];
    logic [31:0] e_dr [2], e_ba [2], e_bd [2];
    int          lat, last;
    logic        ack_bv;
    logic [31:0] ack_ba, ack_bd;

    always #5 clk = ~clk;

    ram_responder #(.MEM_AW(10), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .ram_addr(a[0]), .ram_data_w(d[0]), .ram_read(rd[0]),
        .ram_write(wr[0]), .atomic_i(at[0]), .ram_wait(wt[0]), .ram_data_r(dr[0]),
        .bcast_valid(bv[0]), .bcast_addr(ba[0]), .bcast_data(bd[0]));
    ram_responder #(.MEM_AW(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ram_addr(a[1]), .ram_data_w(d[1]), .ram_read(rd[1]),
        .ram_write(wr[1]), .atomic_i(at[1]), .ram_wait(wt[1]), .ram_data_r(dr[1]),
        .bcast_valid(bv[1]), .bcast_addr(ba[1]), .bcast_data(bd[1]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: a request seen when the port is free is answered WC edges later; port frees WC+2 edges after acceptance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                ack_at[k] = -1; free_at[k] = 0; e_wait[k] = 1'b1; e_bv[k] = 1'b0;
                e_dr[k] = '0; e_ba[k] = '0; e_bd[k] = '0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                e_wait[k] = 1'b1;
                e_bv[k] = 1'b0;
                if (cyc >= free_at[k] && (rd[k] || wr[k])) begin
                    p_wr[k] = wr[k]; p_at[k] = at[k]; p_a[k] = a[k]; p_d[k] = d[k];
                    ack_at[k] = cyc + WC[k];
                    free_at[k] = cyc + WC[k] + 2;
                end
                if (cyc == ack_at[k]) begin
                    e_wait[k] = 1'b0;
                    if (p_wr[k]) mm[k][p_a[k] % 1024] = p_d[k];
                    else e_dr[k] = mm[k][p_a[k] % 1024];
                    if (p_wr[k] && p_at[k]) begin
                        e_bv[k] = 1'b1; e_ba[k] = p_a[k]; e_bd[k] = p_d[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ram_wait[%0d]", k), {31'b0, wt[k]}, {31'b0, e_wait[k]});
            chk($sformatf("ram_data_r[%0d]", k), dr[k], e_dr[k]);
            chk($sformatf("bcast_valid[%0d]", k), {31'b0, bv[k]}, {31'b0, e_bv[k]});
            chk($sformatf("bcast_addr[%0d]", k), ba[k], e_ba[k]);
            chk($sformatf("bcast_data[%0d]", k), bd[k], e_bd[k]);
        end
    end

    task automatic xact(input int k, input bit w, input bit r, input bit atm, input logic [31:0] ad,
                        input logic [31:0] dt, input bit chg, input logic [31:0] alt);
        int acc, n;
        @(negedge clk); #1;
        a[k] = ad; d[k] = dt; wr[k] = w; rd[k] = r; at[k] = atm;
        acc = cyc + 1;
        if (chg) begin
            @(negedge clk); #1;
            a[k] = alt; d[k] = ~dt; at[k] = ~atm;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (wt[k] && n < 20);
        chk("ack_seen", {31'b0, wt[k]}, 32'd0);
        lat = cyc + 1 - acc;
        ack_bv = bv[k]; ack_ba = ba[k]; ack_bd = bd[k];
        #1; rd[k] = 1'b0; wr[k] = 1'b0; at[k] = 1'b0;
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) mm[k][i] = '0;
            a[k] = '0; d[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0; at[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("reset_wait", {31'b0, wt[0]}, 32'd1);
        chk("reset_data_r", dr[0], 32'd0);
        #1 rst = 1'b0;
        xact(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 0, 0);
        chk("write_latency", lat, 3);
        xact(0, 0, 1, 0, 32'h10, 32'h0, 0, 0);
        chk("read_latency", lat, 3);
        chk("read_10", dr[0], 32'hDEADBEEF);
        xact(0, 1, 0, 1, 32'h20, 32'h5, 0, 0);
        chk("atomic_bv", {31'b0, ack_bv}, 32'd1);
        chk("atomic_ba", ack_ba, 32'h20);
        chk("atomic_bd", ack_bd, 32'h5);
        xact(0, 1, 0, 0, 32'h20, 32'h6, 0, 0);
        chk("plain_bv", {31'b0, ack_bv}, 32'd0);
        xact(0, 1, 1, 0, 32'h30, 32'h7, 0, 0);
        chk("rw_data_r_held", dr[0], 32'hDEADBEEF);
        xact(0, 0, 1, 0, 32'h30, 32'h0, 0, 0);
        chk("rw_wrote_30", dr[0], 32'h7);
        @(negedge clk); #1;
        a[0] = 32'h40; d[0] = 32'h9; wr[0] = 1'b1;
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_wait", {31'b0, wt[0]}, 32'd1);
        chk("abort_data_r", dr[0], 32'd0);
        #1 wr[0] = 1'b0;
        @(negedge clk); #1 rst = 1'b0;
        xact(0, 0, 1, 0, 32'h40, 32'h0, 0, 0);
        chk("abort_no_commit", dr[0], 32'h0);
        xact(0, 0, 1, 0, 32'h10, 32'h0, 1, 32'h30);
        chk("latched_addr", dr[0], 32'hDEADBEEF);
        xact(0, 0, 1, 0, 32'h30, 32'h0, 0, 0);
        chk("next_addr", dr[0], 32'h7);
        for (int i = 0; i < 16; i++) xact(1, 1, 0, 0, 32'h100 + 32'(i), 32'hA5000000 + 32'(i * 17), 0, 0);
        chk("w0_latency", lat, 1);
        @(negedge clk); #1;
        a[1] = 32'h100; rd[1] = 1'b1;
        last = 0;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (wt[1] && n < 10);
            chk("fill_ack", {31'b0, wt[1]}, 32'd0);
            chk("fill_data", dr[1], 32'hA5000000 + 32'(i * 17));
            if (i > 0) chk("fill_gap", cyc - last, 2);
            last = cyc;
            #1;
            if (i < 15) a[1] = 32'h101 + 32'(i);
            else rd[1] = 1'b0;
        end
        xact(1, 0, 1, 0, 32'h1D05, 32'h0, 0, 0);
        chk("high_bits_ignored", dr[1], 32'hA5000055);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10: word-address bits of backing storage, giving 2^MEM_AW words of `DATA_W bits.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: number of BUSY cycles per transaction, legal range 0..15.
REQ-003 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ram_addr, input, `DATA_ADDR_W: word address from the cache.
REQ-006 SHALL have port ram_data_w, input, `DATA_W: write data.
REQ-007 SHALL have port ram_read, input, 1: read request level.
REQ-008 SHALL have port ram_write, input, 1: write request level.
REQ-009 SHALL have port atomic_i, input, 1: marks the accepted write as atomic; driven by the cache's cache_atomic_o.
REQ-010 SHALL have port ram_wait, output, 1: 0 only in the acknowledge cycle.
REQ-011 SHALL have port ram_data_r, output, `DATA_W: read data, valid while ram_wait=0 for a read.
REQ-012 SHALL have port bcast_valid, output, 1: one-cycle pulse to the peer caches' cache_atomic_i.
REQ-013 SHALL have port bcast_addr, output, `DATA_ADDR_W: address of the broadcast atomic write.
REQ-014 SHALL have port bcast_data, output, `DATA_W: data of the broadcast atomic write.

Function
REQ-015 SHALL index storage with ram_addr[MEM_AW-1:0]; higher address bits SHALL be ignored.
REQ-016 SHALL use a three-state FSM: IDLE, BUSY, ACK.
REQ-017 In IDLE with ram_read or ram_write high at a clock edge, SHALL latch the address, data, operation and atomic_i.
REQ-018 On that acceptance edge, SHALL go to BUSY when WAIT_CYCLES>0, or directly to ACK when WAIT_CYCLES=0.
REQ-019 In BUSY, SHALL count WAIT_CYCLES cycles and then enter ACK, so an accepted request is acknowledged WAIT_CYCLES+1 edges after acceptance.
REQ-020 ram_wait SHALL be 1 in IDLE and BUSY and 0 for exactly one cycle in ACK; it SHALL be driven from a register, with no combinational path from the inputs.
REQ-021 For a read, ram_data_r SHALL present mem[latched addr] during ACK and SHALL hold that value afterwards until the next read ACK.
REQ-022 For a write, the memory word SHALL be updated on the edge entering ACK, so a read accepted immediately after ACK returns the new data.
REQ-023 If ram_read and ram_write are both high at acceptance, the write SHALL be served and the read SHALL be dropped.
REQ-024 Changes on ram_addr, ram_data_w, atomic_i, or request deassertion while in BUSY or ACK SHALL be ignored; the latched transaction SHALL complete.
REQ-025 From ACK the FSM SHALL go to IDLE; a request still high in IDLE SHALL be accepted as a new transaction on the next edge.
REQ-026 Back-to-back accesses SHALL therefore cost WAIT_CYCLES+2 cycles each.
REQ-027 For an atomic write, bcast_valid SHALL be 1 during the ACK cycle only, with bcast_addr and bcast_data equal to the latched address and data.
REQ-028 For non-atomic writes and for all reads, bcast_valid SHALL stay 0.
REQ-029 bcast_addr and bcast_data SHALL hold their last values when bcast_valid=0.
REQ-030 Storage SHALL be zero-initialised at time 0 and SHALL NOT be cleared by rst.

Reset
REQ-031 While rst=1, regardless of clk, SHALL hold: FSM=IDLE, BUSY counter=0, ram_wait=1, ram_data_r=0, bcast_valid=0, bcast_addr=0, bcast_data=0.
REQ-032 Asserting rst in BUSY SHALL abort the transaction: a pending write SHALL NOT be committed, and no ACK or broadcast SHALL occur.
REQ-033 After rst falls, the first edge with a request high SHALL accept it as a new transaction.

Verification
REQ-034 WAIT_CYCLES=2, write 0xDEADBEEF to 0x10, then read 0x10 -> each ram_wait low exactly one cycle, 3 edges after acceptance; read returns 0xDEADBEEF.
REQ-035 Atomic write of 0x5 to 0x20 -> bcast_valid high one cycle coincident with ram_wait=0, with bcast_addr=0x20 and bcast_data=0x5; a plain write to 0x20 gives no pulse.
REQ-036 ram_read and ram_write both high on address 0x30 with data 0x7 -> mem[0x30]=0x7 and ram_data_r unchanged.
REQ-037 rst pulsed mid-BUSY of a write of 0x9 to 0x40 -> no ACK, mem[0x40] stays 0, ram_wait=1.
REQ-038 WAIT_CYCLES=0, 16 consecutive line-fill reads at 0x100..0x10F -> one ACK every 2 cycles, with data matching preloaded words.
REQ-039 Address changed during BUSY -> the response uses the latched address, and the new address is served on the next transaction.
